// File: rtl/cfg_stream_loader.sv
// ---------------------------------------------------------------------------
// cfg_stream_loader
//
// Writer side of the per-cell config_sig interface that the fabric FUNC_CELLs
// read. A packed configuration stream arrives over a valid/ready word
// interface. The loader unpacks it into a shadow register. It then copies all
// NUM_CELLS fields to cfg_out on a single edge, so a running fabric never sees
// a partially written configuration.
//
// Ports
//   clk           in   1                clock, all state on posedge
//   reset         in   1                synchronous, active-high reset
//   cfg_start     in   1                begin a new load (honoured only in IDLE)
//   cfg_abort     in   1                abandon the current load, shadow discarded
//   cfg_in_valid  in   1                stream word valid
//   cfg_in_data   in   IN_W             stream word, bits packed LSB-first
//   cfg_in_ready  out  1                loader accepts a word this cycle
//   cfg_out       out  NUM_CELLS*CFG_W  committed config, cell k = [k*CFG_W +: CFG_W]
//   cfg_done      out  1                one-cycle pulse, cfg_out just updated
//   busy          out  1                high while loading or committing
// ---------------------------------------------------------------------------
module cfg_stream_loader #(
   parameter int NUM_CELLS = 16,
   parameter int CFG_W     = 4,
   parameter int IN_W      = 8,
   parameter int RESET_OP  = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cfg_start,
   input  logic                       cfg_abort,
   input  logic                       cfg_in_valid,
   input  logic [IN_W-1:0]            cfg_in_data,
   output logic                       cfg_in_ready,
   output logic [NUM_CELLS*CFG_W-1:0] cfg_out,
   output logic                       cfg_done,
   output logic                       busy
);

   localparam int TOTAL  = NUM_CELLS * CFG_W;
   localparam int NWORDS = (TOTAL + IN_W - 1) / IN_W;
   localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_COMMIT
   } state_t;

   state_t             state_q,    state_d;
   logic [IDX_W-1:0]   word_idx_q, word_idx_d;
   logic [TOTAL-1:0]   shadow_q,   shadow_d;
   logic [TOTAL-1:0]   cfg_out_q,  cfg_out_d;
   logic               cfg_done_q, cfg_done_d;
   logic               accept;

   // Ready depends only on the state, never on cfg_in_valid. This keeps the
   // handshake free of combinational loops back to the host.
   assign cfg_in_ready = (state_q == S_LOAD);
   assign accept       = cfg_in_valid & cfg_in_ready;

   assign cfg_out  = cfg_out_q;
   assign cfg_done = cfg_done_q;
   assign busy     = (state_q != S_IDLE);

   always_comb begin
      // NOTE: every signal is given a default first so that no path leaves one
      // unassigned; an unassigned path would infer a latch.
      state_d    = state_q;
      word_idx_d = word_idx_q;
      shadow_d   = shadow_q;
      cfg_out_d  = cfg_out_q;
      cfg_done_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            // When start and abort arrive together, abort wins and the loader stays idle.
            if (cfg_start && !cfg_abort) begin
               state_d    = S_LOAD;
               word_idx_d = '0;
            end
         end

         S_LOAD: begin
            if (cfg_abort) begin
               state_d = S_IDLE;
            end else if (accept) begin
               // Bits of the final word that land past TOTAL have no shadow
               // storage and are dropped here.
               for (int w = 0; w < NWORDS; w++) begin
                  if (word_idx_q == IDX_W'(w)) begin
                     for (int b = 0; b < IN_W; b++) begin
                        if (w * IN_W + b < TOTAL) begin
                           shadow_d[w * IN_W + b] = cfg_in_data[b];
                        end
                     end
                  end
               end
               word_idx_d = word_idx_q + IDX_W'(1);
               if (word_idx_q == IDX_W'(NWORDS - 1)) begin
                  state_d = S_COMMIT;
               end
            end
         end

         S_COMMIT: begin
            state_d = S_IDLE;
            if (!cfg_abort) begin
               cfg_out_d  = shadow_q;
               cfg_done_d = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the value it held before this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         word_idx_q <= '0;
         // NOTE: the shadow is wide, but it still has a defined reset value.
         // An aborted or reset load then never exposes stale data.
         shadow_q   <= '0;
         cfg_out_q  <= {NUM_CELLS{CFG_W'(RESET_OP)}};
         cfg_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         shadow_q   <= shadow_d;
         cfg_out_q  <= cfg_out_d;
         cfg_done_q <= cfg_done_d;
      end
   end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_cfg_stream_loader
//
// Two loaders share one set of input signals.
//   - u_dut4 has NUM_CELLS=4, so the two stream words fill it exactly.
//   - u_dut3 has NUM_CELLS=3, so the top nibble of the second word is dropped.
// Both need two words, so their handshake timing is identical.
//
// A transaction-level model runs alongside them. It tracks idle/loading/
// committing and the list of accepted words, and predicts the expected
// outputs. Each commit pushes the expected configurations into a scoreboard.
// A separate monitor pops an entry whenever cfg_done is seen.
// ---------------------------------------------------------------------------
module tb_cfg_stream_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_start = 1'b0;
   logic        cfg_abort = 1'b0;
   logic        cfg_in_valid = 1'b0;
   logic [7:0]  cfg_in_data = 8'h00;

   logic        ready4, done4, busy4;
   logic [15:0] out4;
   logic        ready3, done3, busy3;
   logic [11:0] out3;

   always #5 clk = ~clk;

   cfg_stream_loader #(.NUM_CELLS(4), .CFG_W(4), .IN_W(8), .RESET_OP(2)) u_dut4 (
      .clk          (clk),
      .reset        (reset),
      .cfg_start    (cfg_start),
      .cfg_abort    (cfg_abort),
      .cfg_in_valid (cfg_in_valid),
      .cfg_in_data  (cfg_in_data),
      .cfg_in_ready (ready4),
      .cfg_out      (out4),
      .cfg_done     (done4),
      .busy         (busy4)
   );

   cfg_stream_loader #(.NUM_CELLS(3), .CFG_W(4), .IN_W(8), .RESET_OP(2)) u_dut3 (
      .clk          (clk),
      .reset        (reset),
      .cfg_start    (cfg_start),
      .cfg_abort    (cfg_abort),
      .cfg_in_valid (cfg_in_valid),
      .cfg_in_data  (cfg_in_data),
      .cfg_in_ready (ready3),
      .cfg_out      (out3),
      .cfg_done     (done3),
      .busy         (busy3)
   );

   typedef struct {
      logic [15:0] e4;
      logic [11:0] e3;
   } sb_entry_t;

   sb_entry_t sb[$];

   int n_total  = 0;
   int n_passed = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end else begin
         n_passed++;
      end
   endtask

   // ---------------- reference model ----------------
   localparam int M_IDLE   = 0;
   localparam int M_LOAD   = 1;
   localparam int M_COMMIT = 2;

   int          m_mode  = M_IDLE;
   bit          m_valid = 1'b0;   // model is meaningful once a reset has been applied
   logic [7:0]  m_words[$];
   logic [15:0] m_out4;
   logic [11:0] m_out3;
   logic        m_done;

   task automatic model_step(input logic r, input logic s, input logic a,
                             input logic v, input logic [7:0] d);
      logic [15:0] full;
      if (r) begin
         m_mode  = M_IDLE;
         m_words.delete();
         m_out4  = 16'h2222;
         m_out3  = 12'h222;
         m_done  = 1'b0;
         m_valid = 1'b1;
      end else begin
         m_done = 1'b0;
         case (m_mode)
            M_IDLE: if (s && !a) begin
               m_mode = M_LOAD;
               m_words.delete();
            end
            M_LOAD: if (a) begin
               m_mode = M_IDLE;
            end else if (v) begin
               m_words.push_back(d);
               if (m_words.size() == 2) m_mode = M_COMMIT;
            end
            default: begin
               if (!a) begin
                  full   = {m_words[1], m_words[0]};
                  m_out4 = full;
                  m_out3 = full[11:0];
                  m_done = 1'b1;
                  sb.push_back('{e4: full, e3: full[11:0]});
               end
               m_mode = M_IDLE;
            end
         endcase
      end
   endtask

   // One clock cycle: check the outputs against the model, then drive new
   // inputs for the next rising edge and advance the model by that edge.
   task automatic cycle(input logic r, input logic s, input logic a,
                        input logic v, input logic [7:0] d);
      @(negedge clk);
      if (m_valid) begin
         check("ready4", {31'd0, ready4}, {31'd0, m_mode == M_LOAD});
         check("busy4",  {31'd0, busy4},  {31'd0, m_mode != M_IDLE});
         check("done4",  {31'd0, done4},  {31'd0, m_done});
         check("out4",   {16'd0, out4},   {16'd0, m_out4});
         check("ready3", {31'd0, ready3}, {31'd0, m_mode == M_LOAD});
         check("busy3",  {31'd0, busy3},  {31'd0, m_mode != M_IDLE});
         check("done3",  {31'd0, done3},  {31'd0, m_done});
         check("out3",   {20'd0, out3},   {20'd0, m_out3});
      end
      reset        = r;
      cfg_start    = s;
      cfg_abort    = a;
      cfg_in_valid = v;
      cfg_in_data  = d;
      model_step(r, s, a, v, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (done4 === 1'b1 || done3 === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", {31'd0, done4}, 32'd0);
         end else begin
            sb_entry_t e;
            e = sb.pop_front();
            check("sb_commit4", {16'd0, out4}, {16'd0, e.e4});
            check("sb_commit3", {20'd0, out3}, {20'd0, e.e3});
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset, then a cycle to observe the reset state.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      idle(2);

      // Back-to-back words.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h53);
      idle(3);

      // Valid gaps between the words.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h87);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'hEE);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'hEE);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'hEE);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h09);
      idle(3);

      // Dropped upper bits on the three-cell loader.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h21);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'hF4);
      idle(3);

      // Abort mid-load, then a fresh load.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
      idle(2);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'hC3);
      idle(3);

      // Abort during the commit cycle: no pulse, and cfg_out is kept.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'hAB);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'hCD);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      idle(2);

      // Start with abort in IDLE stays idle; abort alone in IDLE does nothing.
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h99);
      idle(2);

      // Reset mid-load; a word held before the next start is not taken.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h66);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h66);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h66);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h34);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h12);
      idle(3);

      // Randomised traffic.
      for (int i = 0; i < 1500; i++) begin
         logic r, s, a, v;
         logic [7:0] d;
         r = ($urandom_range(0, 99) < 2);
         s = ($urandom_range(0, 99) < 25);
         a = ($urandom_range(0, 99) < 5);
         v = ($urandom_range(0, 99) < 60);
         d = 8'($urandom);
         cycle(r, s, a, v, d);
      end
      idle(4);

      check("sb_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
